rng_arbiter: RTL and testbench

Shares the single free-running `rng` byte source among `N_REQ` requesters (CPU `Cxkk` RND execute stage, test/debug port, etc.). Each request carries a destination register index and an AND mask. The block arbitrates round-robin, samples the current random byte, masks it, and presents the result on a one-entry write port toward the V-register file. A minimum sample spacing ensures consecutive deliveries never use RNG states closer than `SPACING` cycles apart.

---
 rtl/rng_arbiter.sv | 113 +++++++++++
 tb/tb_rng_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one free-running RNG byte among N_REQ requesters; ack and result one cycle after sampling.
// A held result (wr_valid & !wr_ready) blocks further sampling; SPACING enforces minimum cycles between samples.
module rng_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 4,
    parameter int SPACING = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rnd,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_x,
    input  logic [N_REQ*8-1:0]        req_mask,
    output logic [N_REQ-1:0]          ack,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [7:0]                wr_data,
    output logic [N_REQ-1:0]          wr_src
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = $clog2(SPACING + 1);
    localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   N_WRAP   = (PTR_W + 1)'(N_REQ);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(SPACING);

    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [N_REQ-1:0]  wr_src_q, wr_src_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [PTR_W-1:0]  last_q, last_d;

    logic [N_REQ-1:0]  eligible;
    logic              out_free;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [N_REQ-1:0]  win_onehot;
    logic [PTR_W:0]    cand;
    logic              sample;

    // A requester acknowledged this cycle must not win again before it can react.
    assign eligible = req & ~ack_q;
    assign out_free = !wr_valid_q || wr_ready;

    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_onehot = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (PTR_W + 1)'(last_q) + (PTR_W + 1)'(k);
            if (cand >= N_WRAP) begin
                cand = cand - N_WRAP;
            end
            if (!win_found && eligible[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    assign sample = win_found && (gap_q == GAP_MAX) && out_free;

    always_comb begin
        ack_d      = '0;
        wr_valid_d = wr_valid_q && !wr_ready;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_src_d   = wr_src_q;
        last_d     = last_q;
        gap_d      = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
        if (sample) begin
            ack_d      = win_onehot;
            wr_valid_d = 1'b1;
            wr_addr_d  = req_x[win_idx*ADDR_W +: ADDR_W];
            wr_data_d  = rnd & req_mask[win_idx*8 +: 8];
            wr_src_d   = win_onehot;
            last_d     = win_idx;
            gap_d      = GAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_src_q   <= '0;
            gap_q      <= GAP_MAX;
            last_q     <= LAST_RST;
        end else begin
            ack_q      <= ack_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_src_q   <= wr_src_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
        end
    end

    assign ack      = ack_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_src   = wr_src_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: instance A (2 requesters, SPACING 1) and instance B (3 requesters, SPACING 3).
module tb_rng_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  rnd;
    logic        wr_ready;

    logic [1:0]  req_a;
    logic [7:0]  x_a;
    logic [15:0] mask_a;
    logic [1:0]  ack_a, src_a;
    logic        val_a;
    logic [3:0]  addr_a;
    logic [7:0]  data_a;

    logic [2:0]  req_b;
    logic [11:0] x_b;
    logic [23:0] mask_b;
    logic [2:0]  ack_b, src_b;
    logic        val_b;
    logic [3:0]  addr_b;
    logic [7:0]  data_b;

    wire [16:0] obs_a = {ack_a, val_a, addr_a, data_a, src_a};
    wire [18:0] obs_b = {ack_b, val_b, addr_b, data_b, src_b};

    int checks = 0;
    int errors = 0;

    rng_arbiter #(.N_REQ(2), .ADDR_W(4), .SPACING(1)) u_a (
        .clk(clk), .rst(rst), .rnd(rnd), .req(req_a), .req_x(x_a), .req_mask(mask_a),
        .ack(ack_a), .wr_valid(val_a), .wr_ready(wr_ready), .wr_addr(addr_a),
        .wr_data(data_a), .wr_src(src_a)
    );

    rng_arbiter #(.N_REQ(3), .ADDR_W(4), .SPACING(3)) u_b (
        .clk(clk), .rst(rst), .rnd(rnd), .req(req_b), .req_x(x_b), .req_mask(mask_b),
        .ack(ack_b), .wr_valid(val_b), .wr_ready(wr_ready), .wr_addr(addr_b),
        .wr_data(data_b), .wr_src(src_b)
    );

    // Reference model state, index 0 = instance A, 1 = instance B.
    int         m_last[2];
    int         m_gap[2];
    logic [7:0] m_ack[2];
    logic [7:0] m_src[2];
    logic [7:0] m_data[2];
    logic [3:0] m_addr[2];
    logic       m_valid[2];

    task automatic model_reset();
        m_last[0] = 1; m_gap[0] = 1;
        m_last[1] = 2; m_gap[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_ack[k] = '0; m_src[k] = '0; m_data[k] = '0; m_addr[k] = '0; m_valid[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input int n, input int sp, input logic [7:0] rq,
                              input logic [31:0] xs, input logic [63:0] ms);
        logic [7:0] elig;
        bit found;
        int w;
        elig  = rq & ~m_ack[k];
        found = 0;
        w     = 0;
        for (int off = 1; off <= n; off++) begin
            int i;
            i = (m_last[k] + off) % n;
            if (!found && elig[i]) begin
                found = 1;
                w = i;
            end
        end
        if (found && m_gap[k] == sp && (!m_valid[k] || wr_ready)) begin
            m_data[k]  = rnd & ms[w*8 +: 8];
            m_addr[k]  = xs[w*4 +: 4];
            m_src[k]   = 8'(1 << w);
            m_ack[k]   = 8'(1 << w);
            m_valid[k] = 1'b1;
            m_last[k]  = w;
            m_gap[k]   = 1;
        end else begin
            m_ack[k] = '0;
            if (wr_ready) m_valid[k] = 1'b0;
            if (m_gap[k] < sp) m_gap[k] = m_gap[k] + 1;
        end
    endtask

    function automatic logic [16:0] exp_a();
        return {m_ack[0][1:0], m_valid[0], m_addr[0], m_data[0], m_src[0][1:0]};
    endfunction

    function automatic logic [18:0] exp_b();
        return {m_ack[1][2:0], m_valid[1], m_addr[1], m_data[1], m_src[1][2:0]};
    endfunction

    // One clock: model advances on the edge with the pre-edge inputs, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            model_step(0, 2, 1, {6'b0, req_a}, 32'(x_a), 64'(mask_a));
            model_step(1, 3, 3, {5'b0, req_b}, 32'(x_b), 64'(mask_b));
        end
        #1;
    endtask

    task automatic do_reset();
        req_a = '0; req_b = '0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_a = '0; req_b = '0;
        model_reset();
        #2;
        checks++;
        if (obs_a !== 17'd0 || obs_b !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got a=%h b=%h expected 0", obs_a, obs_b);
        end
        req_a = 2'b11; req_b = 3'b111;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== 17'd0 || obs_b !== 19'd0) begin
            errors++;
            $display("FAIL reset_held: got a=%h b=%h expected 0", obs_a, obs_b);
        end
        req_a = '0; req_b = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_a = 2'b01; x_a = 8'h03; mask_a = 16'h000F; rnd = 8'hA5; wr_ready = 1'b1;
        cycle();
        checks++;
        if (obs_a !== {2'b01, 1'b1, 4'd3, 8'h05, 2'b01} || obs_a !== exp_a()) begin
            errors++;
            $display("FAIL single_request: got %h expected %h", obs_a, {2'b01, 1'b1, 4'd3, 8'h05, 2'b01});
        end
        req_a = 2'b00;
        cycle();
        checks++;
        if (val_a !== 1'b0 || ack_a !== 2'b00 || obs_a !== exp_a()) begin
            errors++;
            $display("FAIL single_drain: got valid=%b ack=%b expected valid=0 ack=00", val_a, ack_a);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] prev;
        logic [1:0] exp_ack;
        int w;
        do_reset();
        req_a = 2'b11; x_a = 8'($urandom); mask_a = 16'($urandom); wr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rnd = 8'($urandom);
            prev = rnd;
            cycle();
            w = c % 2;
            exp_ack = (w == 0) ? 2'b01 : 2'b10;
            checks++;
            if (ack_a !== exp_ack || val_a !== 1'b1 || data_a !== (prev & mask_a[w*8 +: 8])
                || addr_a !== x_a[w*4 +: 4]) begin
                errors++;
                $display("FAIL round_robin[%0d]: got ack=%b data=%h addr=%h expected ack=%b data=%h addr=%h",
                         c, ack_a, data_a, addr_a, exp_ack, prev & mask_a[w*8 +: 8], x_a[w*4 +: 4]);
            end
        end
        req_a = 2'b00;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [7:0] r0, r1, held;
        do_reset();
        req_a = 2'b01; x_a = 8'($urandom); mask_a = 16'($urandom); wr_ready = 1'b0;
        rnd = 8'($urandom); r0 = rnd;
        cycle();
        held = r0 & mask_a[7:0];
        checks++;
        if (ack_a !== 2'b01 || val_a !== 1'b1 || data_a !== held) begin
            errors++;
            $display("FAIL bp_first: got ack=%b valid=%b data=%h expected 01 1 %h", ack_a, val_a, data_a, held);
        end
        req_a = 2'b10;
        for (int c = 0; c < 5; c++) begin
            rnd = 8'($urandom);
            cycle();
            checks++;
            if (ack_a !== 2'b00 || val_a !== 1'b1 || data_a !== held || addr_a !== x_a[3:0] || src_a !== 2'b01) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ack=%b valid=%b data=%h addr=%h expected 00 1 %h %h",
                         c, ack_a, val_a, data_a, addr_a, held, x_a[3:0]);
            end
        end
        wr_ready = 1'b1;
        rnd = 8'($urandom); r1 = rnd;
        cycle();
        checks++;
        if (ack_a !== 2'b10 || val_a !== 1'b1 || data_a !== (r1 & mask_a[15:8]) || addr_a !== x_a[7:4]
            || src_a !== 2'b10 || obs_a !== exp_a()) begin
            errors++;
            $display("FAIL bp_release: got ack=%b data=%h addr=%h expected 10 %h %h",
                     ack_a, data_a, addr_a, r1 & mask_a[15:8], x_a[7:4]);
        end
        req_a = 2'b00;
        cycle();
        checks++;
        if (val_a !== 1'b0 || ack_a !== 2'b00) begin
            errors++;
            $display("FAIL bp_drain: got valid=%b ack=%b expected 0 00", val_a, ack_a);
        end
    endtask

    task automatic test_spacing();
        logic [2:0] exp_ack;
        do_reset();
        req_b = 3'b001; x_b = 12'($urandom); mask_b = 24'($urandom); wr_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            rnd = 8'($urandom);
            cycle();
            exp_ack = (c % 3 == 1) ? 3'b001 : 3'b000;
            checks++;
            if (ack_b !== exp_ack || (exp_ack[0] && data_b !== (rnd & mask_b[7:0]))) begin
                errors++;
                $display("FAIL spacing[%0d]: got ack=%b data=%h expected ack=%b data=%h",
                         c, ack_b, data_b, exp_ack, rnd & mask_b[7:0]);
            end
        end
        req_b = 3'b000;
        cycle();
    endtask

    task automatic test_mask();
        do_reset();
        req_a = 2'b01; x_a = 8'($urandom); mask_a = 16'hFF00; wr_ready = 1'b1;
        rnd = 8'($urandom) | 8'h81;
        cycle();
        checks++;
        if (val_a !== 1'b1 || data_a !== 8'h00) begin
            errors++;
            $display("FAIL mask_zero: got valid=%b data=%h expected 1 00", val_a, data_a);
        end
        req_a = 2'b10; rnd = 8'h3C;
        cycle();
        checks++;
        if (ack_a !== 2'b10 || data_a !== 8'h3C) begin
            errors++;
            $display("FAIL mask_ones: got ack=%b data=%h expected 10 3c", ack_a, data_a);
        end
        req_a = 2'b00;
        cycle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_a = 2'b10; x_a = 8'($urandom); mask_a = 16'($urandom); wr_ready = 1'b0;
        rnd = 8'($urandom);
        cycle();
        checks++;
        if (ack_a !== 2'b10 || val_a !== 1'b1) begin
            errors++;
            $display("FAIL midflight_pre: got ack=%b valid=%b expected 10 1", ack_a, val_a);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs_a !== 17'd0 || obs_b !== 19'd0) begin
            errors++;
            $display("FAIL midflight_async: got a=%h b=%h expected 0", obs_a, obs_b);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        rnd = 8'($urandom);
        cycle();
        checks++;
        if (ack_a !== 2'b10 || val_a !== 1'b1 || data_a !== (rnd & mask_a[15:8]) || obs_a !== exp_a()) begin
            errors++;
            $display("FAIL midflight_after: got ack=%b valid=%b data=%h expected 10 1 %h",
                     ack_a, val_a, data_a, rnd & mask_a[15:8]);
        end
        req_a = 2'b00; wr_ready = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_a  = 2'($urandom) | 2'($urandom);
            req_b  = 3'($urandom) | 3'($urandom);
            x_a    = 8'($urandom);
            x_b    = 12'($urandom);
            mask_a = ($urandom_range(0, 7) == 0) ? 16'hFF00 : 16'($urandom);
            mask_b = ($urandom_range(0, 7) == 0) ? 24'h00FFFF : 24'($urandom);
            rnd    = 8'($urandom);
            wr_ready = ($urandom_range(0, 3) != 0);
            cycle();
            checks++;
            if (obs_a !== exp_a()) begin
                errors++;
                $display("FAIL random_a[%0d]: got %h expected %h", c, obs_a, exp_a());
            end
            checks++;
            if (obs_b !== exp_b()) begin
                errors++;
                $display("FAIL random_b[%0d]: got %h expected %h", c, obs_b, exp_b());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rnd = '0; wr_ready = 1'b1;
        req_a = '0; x_a = '0; mask_a = '0;
        req_b = '0; x_b = '0; mask_b = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_spacing();
        test_mask();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
